rr_request_tracker: RTL

- Upstream feeder for the round-robin arbiter. Keeps a per-client count of pending transactions and drives the arbiter's request vector.
- request[i] stays high until every pending transaction for client i has been granted. This guarantees the arbiter-side rule "a request, once raised, stays stable until granted".
- Consumes the arbiter's grant and stall outputs, and flags protocol errors.

---
 rtl/rr_arbiter_pkg.sv | 17 +
 rtl/rr_request_tracker_if.sv | 31 +++
 rtl/rr_pending_counter.sv | 60 ++++++
 rtl/rr_request_tracker.sv | 72 +++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter and its request tracker.
package rr_arbiter_pkg;

  localparam int unsigned CLIENTS_DEFAULT = 32;
  localparam int unsigned CNT_W_DEFAULT   = 4;
  localparam int unsigned NUM_ERR         = 3;

  typedef logic [CNT_W_DEFAULT-1:0] pend_cnt_t;

  // Bit positions of the sticky error flags; also used by the arbiter checkers.
  typedef enum logic [1:0] {
    OVERFLOW  = 2'd0,
    UNDERFLOW = 2'd1,
    ONEHOT    = 2'd2
  } err_code_e;

endpackage

// File: rtl/rr_request_tracker_if.sv
// Handshake bundle between the request tracker, its feeder and the arbiter.
interface rr_request_tracker_if
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned CLIENTS = CLIENTS_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned SEL_W   = $clog2(CLIENTS)
);

  logic [CLIENTS-1:0] push;
  logic [CLIENTS-1:0] grant;
  logic               stall;
  logic [CLIENTS-1:0] request;
  logic [CLIENTS-1:0] full;
  logic [SEL_W-1:0]   count_sel;
  logic [CNT_W-1:0]   count_out;
  logic               overflow_err;
  logic               underflow_err;
  logic               onehot_err;

  modport master (
    output push, grant, stall, count_sel,
    input  request, full, count_out, overflow_err, underflow_err, onehot_err
  );

  modport slave (
    input  push, grant, stall, count_sel,
    output request, full, count_out, overflow_err, underflow_err, onehot_err
  );

endinterface

// File: rtl/rr_pending_counter.sv
// Single-client saturating pending-transaction counter; never wraps in either direction.
module rr_pending_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_consume,
  output logic [CNT_W-1:0] o_count,
  output logic             o_nonzero,
  output logic             o_full,
  output logic             o_over,
  output logic             o_under
);

  localparam logic [CNT_W-1:0] MaxCnt = '1;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             w_nonzero;
  logic             w_full;

  assign w_nonzero = (r_count != '0);
  assign w_full    = (r_count == MaxCnt);

  always_comb begin
    w_count_next = r_count;
    o_over       = 1'b0;
    o_under      = 1'b0;
    case ({i_push, i_consume})
      2'b10: begin
        if (w_full) o_over = 1'b1;
        else        w_count_next = r_count + 1'b1;
      end
      2'b01: begin
        if (w_nonzero) w_count_next = r_count - 1'b1;
        else           o_under = 1'b1;
      end
      2'b11: begin
        // Push and grant cancel out; at zero the push lands but the grant was bogus.
        if (!w_nonzero) begin
          w_count_next    = '0;
          w_count_next[0] = 1'b1;
          o_under         = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_count <= '0;
    else       r_count <= w_count_next;
  end

  assign o_count   = r_count;
  assign o_nonzero = w_nonzero;
  assign o_full    = w_full;

endmodule

// File: rtl/rr_request_tracker.sv
// Per-client pending counters driving the arbiter request vector, with sticky protocol errors.
module rr_request_tracker
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned CLIENTS = CLIENTS_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input logic                 clock,
  input logic                 reset,
  rr_request_tracker_if.slave io_bus
);

  logic [CLIENTS-1:0] w_consume;
  logic [CLIENTS-1:0] w_nonzero;
  logic [CLIENTS-1:0] w_full;
  logic [CLIENTS-1:0] w_over;
  logic [CLIENTS-1:0] w_under;
  logic [CNT_W-1:0]   w_count [CLIENTS];
  logic               w_multi;
  logic [NUM_ERR-1:0] r_err;
  logic [NUM_ERR-1:0] w_err_next;
  logic [CNT_W-1:0]   w_count_out;

  assign w_consume = io_bus.grant & {CLIENTS{~io_bus.stall}};

  for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_client
    rr_pending_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clock     (clock),
      .reset     (reset),
      .i_push    (io_bus.push[gi]),
      .i_consume (w_consume[gi]),
      .o_count   (w_count[gi]),
      .o_nonzero (w_nonzero[gi]),
      .o_full    (w_full[gi]),
      .o_over    (w_over[gi]),
      .o_under   (w_under[gi])
    );
  end

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign w_multi = |(w_consume & (w_consume - 1'b1));

  always_comb begin
    w_err_next = r_err;
    if (|w_over)  w_err_next[OVERFLOW]  = 1'b1;
    if (|w_under) w_err_next[UNDERFLOW] = 1'b1;
    if (w_multi)  w_err_next[ONEHOT]    = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) r_err <= '0;
    else       r_err <= w_err_next;
  end

  // Out-of-range selects match no client and read back zero.
  always_comb begin
    w_count_out = '0;
    for (int unsigned i = 0; i < CLIENTS; i++) begin
      if (32'(io_bus.count_sel) == i) w_count_out = w_count[i];
    end
  end

  assign io_bus.request       = w_nonzero;
  assign io_bus.full          = w_full;
  assign io_bus.count_out     = w_count_out;
  assign io_bus.overflow_err  = r_err[OVERFLOW];
  assign io_bus.underflow_err = r_err[UNDERFLOW];
  assign io_bus.onehot_err    = r_err[ONEHOT];

endmodule
